// File: rtl/pushbutton_conditioner.sv
// Conditions the raw board buttons for the uP's pushbuttons input port.
// Each bit goes through a two-flop synchronizer, a four-state debounce FSM
// and a rising-edge detector. The debounced level reaches the uP only while
// phase is 0 (fetch), so the input port never changes mid-instruction.
module pushbutton_conditioner #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] buttons_raw,
  input  logic             phase,
  input  logic [WIDTH-1:0] clear_press,
  output logic [WIDTH-1:0] pushbuttons,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] press_latched
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE0 = 2'd0,
    PEND1   = 2'd1,
    STABLE1 = 2'd2,
    PEND0   = 2'd3
  } state_t;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] deb_next;
  logic [WIDTH-1:0] pulse_next;

  // Two-flop synchronizer; only s2 is used downstream
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= buttons_raw;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Debounce state and stability counter
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        state <= STABLE0;
        cnt   <= '0;
      end else begin
        state <= state_next;
        cnt   <= cnt_next;
      end
    end

    // Next state: a level change must stay put for DEBOUNCE_CYCLES samples
    always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
        STABLE0: begin
          if (s2[i]) begin
            state_next = PEND1;
            cnt_next   = CNT_ONE;
          end
        end
        PEND1: begin
          if (!s2[i]) begin
            state_next = STABLE0;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = STABLE1;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        STABLE1: begin
          if (!s2[i]) begin
            state_next = PEND0;
            cnt_next   = CNT_ONE;
          end
        end
        PEND0: begin
          if (s2[i]) begin
            state_next = STABLE1;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = STABLE0;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
        default: begin
          state_next = STABLE0;
          cnt_next   = '0;
        end
      endcase
    end

    assign deb_next[i]   = (state_next == STABLE1) || (state_next == PEND0);
    assign pulse_next[i] = (state == PEND1) && (state_next == STABLE1);
  end

  // Output registers; a press sets the sticky flag even when cleared on the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      debounced     <= '0;
      press_pulse   <= '0;
      press_latched <= '0;
      pushbuttons   <= '0;
    end else begin
      debounced     <= deb_next;
      press_pulse   <= pulse_next;
      press_latched <= (press_latched & ~clear_press) | pulse_next;
      if (!phase) begin
        pushbuttons <= debounced;
      end
    end
  end

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Directed bench for pushbutton_conditioner with DEBOUNCE_CYCLES = 4.
// Inputs change just after a falling edge; outputs are sampled on falling edges.
module tb_pushbutton_conditioner;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] buttons_raw;
  logic       phase;
  logic [3:0] clear_press;
  logic [3:0] pushbuttons;
  logic [3:0] debounced;
  logic [3:0] press_pulse;
  logic [3:0] press_latched;

  int compared   = 0;
  int mismatched = 0;

  pushbutton_conditioner #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .buttons_raw(buttons_raw),
    .phase(phase),
    .clear_press(clear_press),
    .pushbuttons(pushbuttons),
    .debounced(debounced),
    .press_pulse(press_pulse),
    .press_latched(press_latched)
  );

  // Free-running clock, 10 time units per period
  always #5 clock = ~clock;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_output(input string tag, input logic [3:0] observed,
                              input logic [3:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Linear directed sequence
  initial begin
    reset       = 1'b0;
    buttons_raw = 4'b0110;
    phase       = 1'b0;
    clear_press = 4'b0000;

    // Reset state
    wait_cycles(3);
    check_output("reset_debounced", debounced, 4'b0000);
    check_output("reset_pushbuttons", pushbuttons, 4'b0000);
    check_output("reset_pulse", press_pulse, 4'b0000);
    check_output("reset_latched", press_latched, 4'b0000);

    // 1: press bits 1,2 held from reset release
    reset = 1'b1;
    wait_cycles(5);
    check_output("t1_deb_before_E5", debounced, 4'b0000);
    wait_cycles(1);
    check_output("t1_deb_E5", debounced, 4'b0110);
    check_output("t1_pulse_E5", press_pulse, 4'b0110);
    check_output("t1_latched_E5", press_latched, 4'b0110);
    check_output("t1_pb_E5", pushbuttons, 4'b0000);
    wait_cycles(1);
    check_output("t1_pb_E6", pushbuttons, 4'b0110);
    check_output("t1_pulse_E6", press_pulse, 4'b0000);

    // 2: bit 0 bounce lasting 3 cycles is rejected
    buttons_raw = 4'b0111;
    wait_cycles(3);
    buttons_raw = 4'b0110;
    for (int k = 0; k < 8; k++) begin
      check_output("t2_bounce_bit0",
                   {1'b0, debounced[0], press_pulse[0], press_latched[0]}, 4'b0000);
      wait_cycles(1);
    end
    check_output("t2_deb_after", debounced, 4'b0110);

    // 3: bit 3 press with phase held at execute
    phase       = 1'b1;
    buttons_raw = 4'b1110;
    wait_cycles(6);
    check_output("t3_deb", debounced, 4'b1110);
    check_output("t3_pulse", press_pulse, 4'b1000);
    check_output("t3_pb_held", pushbuttons, 4'b0110);
    wait_cycles(2);
    check_output("t3_pb_still_held", pushbuttons, 4'b0110);
    phase = 1'b0;
    wait_cycles(1);
    check_output("t3_pb_loaded", pushbuttons, 4'b1110);

    // 4: clear flags, then set-wins when clear coincides with a press
    check_output("t4_latched_before", press_latched, 4'b1110);
    clear_press = 4'b0010;
    wait_cycles(1);
    clear_press = 4'b0000;
    check_output("t4_cleared_bit1", press_latched, 4'b1100);
    buttons_raw = 4'b1111;
    wait_cycles(5);
    clear_press = 4'b0001;
    wait_cycles(1);
    clear_press = 4'b0000;
    check_output("t4_pulse_bit0", press_pulse, 4'b0001);
    check_output("t4_set_wins", press_latched, 4'b1101);
    wait_cycles(1);
    check_output("t4_latched_kept", press_latched, 4'b1101);
    clear_press = 4'b0001;
    wait_cycles(1);
    check_output("t4_cleared_bit0", press_latched, 4'b1100);
    clear_press = 4'b0011;
    wait_cycles(1);
    clear_press = 4'b0000;
    check_output("t4_clear_when_zero", press_latched, 4'b1100);

    // 5: release of bit 1 gives no pulse and leaves flags alone
    buttons_raw = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      wait_cycles(1);
      check_output("t5_no_pulse", press_pulse, 4'b0000);
    end
    check_output("t5_deb_before_E5", debounced, 4'b1111);
    wait_cycles(1);
    check_output("t5_deb_released", debounced, 4'b1101);
    check_output("t5_no_pulse_E5", press_pulse, 4'b0000);
    check_output("t5_latched", press_latched, 4'b1100);
    wait_cycles(1);
    check_output("t5_pb", pushbuttons, 4'b1101);

    // 6: asynchronous reset in the middle of a bit-0 debounce
    buttons_raw = 4'b1100;
    wait_cycles(7);
    check_output("t6_deb_idle", debounced, 4'b1100);
    buttons_raw = 4'b1101;
    wait_cycles(4);
    #2 reset = 1'b0;
    #1;
    check_output("t6_async_deb", debounced, 4'b0000);
    check_output("t6_async_pb", pushbuttons, 4'b0000);
    check_output("t6_async_pulse", press_pulse, 4'b0000);
    check_output("t6_async_latched", press_latched, 4'b0000);
    wait_cycles(1);
    reset = 1'b1;
    wait_cycles(5);
    check_output("t6_no_early_accept", debounced, 4'b0000);
    check_output("t6_no_early_pulse", press_pulse, 4'b0000);
    wait_cycles(1);
    check_output("t6_deb_redone", debounced, 4'b1101);
    check_output("t6_pulse_redone", press_pulse, 4'b1101);
    check_output("t6_latched_redone", press_latched, 4'b1101);
    wait_cycles(1);
    check_output("t6_pb_redone", pushbuttons, 4'b1101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
